// File: rtl/lane_runner_core.sv
// Lane-dodging game core: tick-paced car slide, falling obstacles, scoring and
// a one-clock registered pixel renderer.
module lane_runner_core #(
  parameter int NUM_LANES      = 3,
  parameter int NUM_OBS        = 4,
  parameter int LANE0_X        = 220,
  parameter int LANE_PITCH     = 140,
  parameter int TICK_BITS      = 22,
  parameter int SPAWN_GAP      = 40,
  parameter int SPEED_UP_EVERY = 5,
  parameter int MAX_STEP       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_c,
  input  logic        bright,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [11:0] rgb,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [1:0]  game_state
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [2:0]           MID_LANE   = 3'(NUM_LANES / 2);
  localparam logic [2:0]           LAST_LANE  = 3'(NUM_LANES - 1);
  localparam logic [7:0]           PTS_WRAP   = 8'(SPEED_UP_EVERY - 1);
  localparam logic [15:0]          SPAWN_WRAP = 16'(SPAWN_GAP - 1);
  localparam logic [TICK_BITS-1:0] TICK_ONE   = {{(TICK_BITS-1){1'b0}}, 1'b1};

  function automatic logic [10:0] lane_center(input logic [2:0] lane);
    return 11'(LANE0_X + int'(lane) * LANE_PITCH);
  endfunction

  state_t               state_r, state_nxt;
  logic [TICK_BITS-1:0] tick_cnt_r;
  logic [7:0]           lfsr_r, level_r, level_nxt, pts_r, pts_nxt;
  logic [2:0]           btn_prev_r, btn_edge_r;
  logic [2:0]           lane_r, lane_nxt, spawn_lane_s;
  logic [10:0]          car_x_r, car_x_nxt, target_s, new_y_s;
  logic [NUM_OBS-1:0]   valid_r, valid_nxt, hit_r, hit_nxt, hit_s, obs_in_s;
  logic [2:0]           olane_r [NUM_OBS];
  logic [2:0]           olane_nxt [NUM_OBS];
  logic [9:0]           oy_r [NUM_OBS];
  logic [9:0]           oy_nxt [NUM_OBS];
  logic [15:0]          score_r, score_nxt, high_r, high_nxt, spawn_r, spawn_nxt;
  logic [11:0]          rgb_r, rgb_nxt;
  logic [8:0]           lvl_inc_s, step_s;
  logic                 tick_s, placed_s, player_px_s, div_px_s;

  assign tick_s       = (tick_cnt_r == {TICK_BITS{1'b0}});
  assign target_s     = lane_center(lane_r);
  assign lvl_inc_s    = {1'b0, level_r} + 9'd1;
  assign step_s       = (lvl_inc_s > 9'(MAX_STEP)) ? 9'(MAX_STEP) : lvl_inc_s;
  assign spawn_lane_s = 3'(lfsr_r % 8'(NUM_LANES));

  // Collision of each live obstacle box with the player box (strict overlap).
  always_comb begin
    hit_s = {NUM_OBS{1'b0}};
    for (int i = 0; i < NUM_OBS; i++) begin
      hit_s[i] = valid_r[i]
               && (lane_center(olane_r[i]) + 11'd40 > car_x_r)
               && (car_x_r + 11'd40 > lane_center(olane_r[i]))
               && (oy_r[i] > 10'd360) && (oy_r[i] < 10'd440);
    end
  end

  // Game FSM next state and tick-driven datapath updates.
  always_comb begin
    state_nxt = state_r;
    lane_nxt  = lane_r;
    car_x_nxt = car_x_r;
    valid_nxt = valid_r;
    hit_nxt   = hit_r;
    olane_nxt = olane_r;
    oy_nxt    = oy_r;
    score_nxt = score_r;
    high_nxt  = high_r;
    level_nxt = level_r;
    pts_nxt   = pts_r;
    spawn_nxt = spawn_r;
    placed_s  = 1'b0;
    new_y_s   = 11'd0;
    case (state_r)
      ST_START: begin
        lane_nxt  = MID_LANE;
        car_x_nxt = lane_center(MID_LANE);
        valid_nxt = {NUM_OBS{1'b0}};
        hit_nxt   = {NUM_OBS{1'b0}};
        score_nxt = 16'd0;
        level_nxt = 8'd0;
        pts_nxt   = 8'd0;
        spawn_nxt = 16'd0;
        if (btn_edge_r[2]) state_nxt = ST_PLAY;
        else               state_nxt = ST_START;
      end
      ST_PLAY: begin
        // Lane changes only once the car has settled on its target.
        if (car_x_r == target_s && btn_edge_r[0] && !btn_edge_r[1] && lane_r != 3'd0)
          lane_nxt = lane_r - 3'd1;
        else if (car_x_r == target_s && btn_edge_r[1] && !btn_edge_r[0] && lane_r < LAST_LANE)
          lane_nxt = lane_r + 3'd1;
        else
          lane_nxt = lane_r;
        if (tick_s) begin
          if (car_x_r < target_s)
            car_x_nxt = (target_s - car_x_r < 11'd5) ? target_s : car_x_r + 11'd5;
          else if (car_x_r > target_s)
            car_x_nxt = (car_x_r - target_s < 11'd5) ? target_s : car_x_r - 11'd5;
          else
            car_x_nxt = car_x_r;
          for (int i = 0; i < NUM_OBS; i++) begin
            new_y_s = 11'(oy_r[i]) + 11'(step_s);
            if (valid_r[i] && new_y_s >= 11'd480) begin
              valid_nxt[i] = 1'b0;
              if (score_nxt != 16'hFFFF) begin
                score_nxt = score_nxt + 16'd1;
                if (pts_nxt == PTS_WRAP) begin
                  pts_nxt   = 8'd0;
                  level_nxt = (level_nxt == 8'hFF) ? level_nxt : level_nxt + 8'd1;
                end else begin
                  pts_nxt = pts_nxt + 8'd1;
                end
              end else begin
                score_nxt = score_nxt;
              end
            end else if (valid_r[i]) begin
              oy_nxt[i] = new_y_s[9:0];
            end else begin
              valid_nxt[i] = 1'b0;
            end
          end
          if (spawn_r == SPAWN_WRAP) begin
            spawn_nxt = 16'd0;
            for (int i = 0; i < NUM_OBS; i++) begin
              if (!valid_nxt[i] && !placed_s) begin
                valid_nxt[i] = 1'b1;
                oy_nxt[i]    = 10'd0;
                olane_nxt[i] = spawn_lane_s;
                placed_s     = 1'b1;
              end else begin
                placed_s = placed_s;
              end
            end
          end else begin
            spawn_nxt = spawn_r + 16'd1;
          end
        end else begin
          car_x_nxt = car_x_r;
        end
        if (|hit_s) begin
          state_nxt = ST_OVER;
          hit_nxt   = hit_s;
          high_nxt  = (score_nxt > high_r) ? score_nxt : high_r;
        end else if (btn_edge_r[2]) begin
          state_nxt = ST_PAUSE;
        end else begin
          state_nxt = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (btn_edge_r[2]) state_nxt = ST_PLAY;
        else               state_nxt = ST_PAUSE;
      end
      ST_OVER: begin
        if (btn_edge_r[2]) state_nxt = ST_START;
        else               state_nxt = ST_OVER;
      end
      default: state_nxt = ST_START;
    endcase
  end

  // Pixel classification and colour priority for the registered rgb output.
  always_comb begin
    player_px_s = ({1'b0, hcount} + 11'd20 >= car_x_r) && ({1'b0, hcount} < car_x_r + 11'd20)
                && (vcount >= 10'd400) && (vcount < 10'd440);
    obs_in_s = {NUM_OBS{1'b0}};
    for (int i = 0; i < NUM_OBS; i++) begin
      obs_in_s[i] = valid_r[i]
                  && ({1'b0, hcount} + 11'd20 >= lane_center(olane_r[i]))
                  && ({1'b0, hcount} < lane_center(olane_r[i]) + 11'd20)
                  && (vcount >= oy_r[i]) && ({1'b0, vcount} < {1'b0, oy_r[i]} + 11'd40);
    end
    div_px_s = 1'b0;
    for (int k = 0; k < NUM_LANES - 1; k++) begin
      div_px_s = div_px_s | ({1'b0, hcount} == 11'(LANE0_X + k * LANE_PITCH + LANE_PITCH / 2));
    end
    if (!bright)
      rgb_nxt = 12'h000;
    else if (player_px_s)
      rgb_nxt = (state_r == ST_OVER) ? 12'hF00 : 12'hFFF;
    else if (|obs_in_s)
      rgb_nxt = (state_r == ST_OVER && |(obs_in_s & hit_r)) ? 12'hF00 : 12'h0F0;
    else if (div_px_s)
      rgb_nxt = 12'h888;
    else
      rgb_nxt = 12'h000;
  end

  // All state registers; reset overrides any slide, spawn or collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_START;
      tick_cnt_r <= {TICK_BITS{1'b0}};
      lfsr_r     <= 8'hAC;
      btn_prev_r <= 3'd0;
      btn_edge_r <= 3'd0;
      lane_r     <= MID_LANE;
      car_x_r    <= lane_center(MID_LANE);
      valid_r    <= {NUM_OBS{1'b0}};
      hit_r      <= {NUM_OBS{1'b0}};
      score_r    <= 16'd0;
      high_r     <= 16'd0;
      level_r    <= 8'd0;
      pts_r      <= 8'd0;
      spawn_r    <= 16'd0;
      rgb_r      <= 12'h000;
      for (int i = 0; i < NUM_OBS; i++) begin
        olane_r[i] <= 3'd0;
        oy_r[i]    <= 10'd0;
      end
    end else begin
      state_r    <= state_nxt;
      tick_cnt_r <= tick_cnt_r + TICK_ONE;
      lfsr_r     <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
      btn_prev_r <= {btn_c, btn_r, btn_l};
      btn_edge_r <= {btn_c, btn_r, btn_l} & ~btn_prev_r;
      lane_r     <= lane_nxt;
      car_x_r    <= car_x_nxt;
      valid_r    <= valid_nxt;
      hit_r      <= hit_nxt;
      score_r    <= score_nxt;
      high_r     <= high_nxt;
      level_r    <= level_nxt;
      pts_r      <= pts_nxt;
      spawn_r    <= spawn_nxt;
      rgb_r      <= rgb_nxt;
      for (int i = 0; i < NUM_OBS; i++) begin
        olane_r[i] <= olane_nxt[i];
        oy_r[i]    <= oy_nxt[i];
      end
    end
  end

  assign rgb        = rgb_r;
  assign score      = score_r;
  assign high_score = high_r;
  assign game_state = state_r;

endmodule

// File: tb/tb_lane_runner_core.sv
// Randomised play of lane_runner_core checked every clock against a
// rule-level game model kept in plain integers and arrays.
module tb_lane_runner_core;
  localparam int NL = 3, NO = 2, L0 = 220, LP = 140, TB = 3, GAP = 6, SUE = 2, MS = 8;

  logic        clk = 1'b0;
  logic        reset, btn_l, btn_r, btn_c, bright;
  logic [9:0]  hcount, vcount;
  logic [11:0] rgb;
  logic [15:0] score, high_score;
  logic [1:0]  game_state;

  always #5 clk = ~clk;

  lane_runner_core #(
    .NUM_LANES(NL), .NUM_OBS(NO), .LANE0_X(L0), .LANE_PITCH(LP), .TICK_BITS(TB),
    .SPAWN_GAP(GAP), .SPEED_UP_EVERY(SUE), .MAX_STEP(MS)
  ) dut (
    .clk(clk), .reset(reset), .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c),
    .bright(bright), .hcount(hcount), .vcount(vcount), .rgb(rgb),
    .score(score), .high_score(high_score), .game_state(game_state)
  );

  int tests = 0, fails = 0;
  int m_st, m_tick, m_lfsr, m_lane, m_car, m_score, m_hs, m_spawn, m_rgb;
  int m_prev[3], m_edge[3];
  int m_valid[NO], m_olane[NO], m_oy[NO], m_hit[NO];
  int hold_cnt, hc, vc, pick, sl;

  function automatic int center(int l);
    return L0 + l * LP;
  endfunction

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  function automatic int lane_busy(int l, int ymin);
    for (int i = 0; i < NO; i++)
      if (m_valid[i] != 0 && m_olane[i] == l && m_oy[i] > ymin && m_oy[i] < 440) return 1;
    return 0;
  endfunction

  function automatic int render();
    int px, py, obs, red;
    px = int'(hcount); py = int'(vcount); obs = 0; red = 0;
    if (!bright) return 0;
    if (px >= m_car - 20 && px < m_car + 20 && py >= 400 && py < 440)
      return (m_st == 2) ? 32'h0F00 : 32'h0FFF;
    for (int i = 0; i < NO; i++) begin
      if (m_valid[i] != 0 && px >= center(m_olane[i]) - 20 && px < center(m_olane[i]) + 20
          && py >= m_oy[i] && py < m_oy[i] + 40) begin
        obs = 1;
        if (m_hit[i] != 0) red = 1;
      end
    end
    if (obs != 0) return (m_st == 2 && red != 0) ? 32'h0F00 : 32'h00F0;
    for (int k = 0; k < NL - 1; k++)
      if (px == L0 + k * LP + LP / 2) return 32'h0888;
    return 0;
  endfunction

  task automatic start_vals();
    m_lane = NL / 2; m_car = center(NL / 2); m_score = 0; m_spawn = 0;
    for (int i = 0; i < NO; i++) begin m_valid[i] = 0; m_hit[i] = 0; end
  endtask

  task automatic model_step();
    int oe[3];
    int hitm[NO];
    int tk, lf_old, tgt, old_car, step, ret, col, fb, placed, d;
    m_rgb = render();
    oe = m_edge;
    tk = (m_tick == 0) ? 1 : 0;
    lf_old = m_lfsr;
    m_edge[0] = (btn_l && m_prev[0] == 0) ? 1 : 0;
    m_edge[1] = (btn_r && m_prev[1] == 0) ? 1 : 0;
    m_edge[2] = (btn_c && m_prev[2] == 0) ? 1 : 0;
    m_prev[0] = int'(btn_l); m_prev[1] = int'(btn_r); m_prev[2] = int'(btn_c);
    m_tick = (m_tick + 1) % (1 << TB);
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = ((m_lfsr << 1) & 255) | fb;
    if (reset) begin
      m_st = 0; start_vals(); m_hs = 0; m_lfsr = 172; m_tick = 0; m_rgb = 0;
      for (int j = 0; j < 3; j++) begin m_prev[j] = 0; m_edge[j] = 0; end
    end else begin
      case (m_st)
        0: begin start_vals(); if (oe[2] != 0) m_st = 1; end
        1: begin
          col = 0;
          for (int i = 0; i < NO; i++) begin
            d = center(m_olane[i]) - m_car;
            hitm[i] = (m_valid[i] != 0 && d > -40 && d < 40 && m_oy[i] > 360 && m_oy[i] < 440) ? 1 : 0;
            col = col | hitm[i];
          end
          old_car = m_car; tgt = center(m_lane);
          if (tk != 0) begin
            if (m_car < tgt) m_car = (tgt - m_car < 5) ? tgt : m_car + 5;
            else if (m_car > tgt) m_car = (m_car - tgt < 5) ? tgt : m_car - 5;
            step = 1 + m_score / SUE;
            if (step > MS) step = MS;
            ret = 0;
            for (int i = 0; i < NO; i++) begin
              if (m_valid[i] != 0) begin
                m_oy[i] += step;
                if (m_oy[i] >= 480) begin m_valid[i] = 0; ret++; end
              end
            end
            m_score = (m_score + ret > 65535) ? 65535 : m_score + ret;
            m_spawn++;
            if (m_spawn == GAP) begin
              m_spawn = 0; placed = 0;
              for (int i = 0; i < NO; i++) begin
                if (placed == 0 && m_valid[i] == 0) begin
                  m_valid[i] = 1; m_oy[i] = 0; m_olane[i] = lf_old % NL; placed = 1;
                end
              end
            end
          end
          if (old_car == tgt && oe[0] != oe[1]) begin
            if (oe[0] != 0 && m_lane > 0) m_lane--;
            else if (oe[1] != 0 && m_lane < NL - 1) m_lane++;
          end
          if (col != 0) begin
            m_st = 2;
            if (m_score > m_hs) m_hs = m_score;
            m_hit = hitm;
          end else if (oe[2] != 0) begin
            m_st = 3;
          end
        end
        3: if (oe[2] != 0) m_st = 1;
        default: if (oe[2] != 0) m_st = 0;
      endcase
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("game_state", 32'(game_state), m_st);
    check("score", 32'(score), m_score);
    check("high_score", 32'(high_score), m_hs);
    check("rgb", 32'(rgb), m_rgb);
  endtask

  initial begin
    reset = 1'b1; btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
    bright = 1'b0; hcount = 10'd0; vcount = 10'd0; hold_cnt = 0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check("reset_state", 32'(game_state), 32'd0);

    // Pixels in START: player white, both dividers gray, blanking black.
    bright = 1'b1; hcount = 10'd360; vcount = 10'd420; cyc();
    check("start_player_px", 32'(rgb), 32'h0FFF);
    hcount = 10'd290; vcount = 10'd10; cyc();
    check("divider0_px", 32'(rgb), 32'h0888);
    hcount = 10'd430; cyc();
    check("divider1_px", 32'(rgb), 32'h0888);
    bright = 1'b0; cyc();
    check("blank_px", 32'(rgb), 32'h0000);

    // btn_c edge reaches PLAY two clocks later; holding it changes nothing more.
    btn_c = 1'b1; cyc();
    check("btn_c_1clk", 32'(game_state), 32'd0);
    cyc();
    check("btn_c_2clk", 32'(game_state), 32'd1);
    repeat (98) cyc();
    check("btn_c_held", 32'(game_state), 32'd1);
    btn_c = 1'b0;

    for (int n = 0; n < 40000; n++) begin
      reset  = ($urandom_range(0, 4999) == 0);
      bright = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0: begin hc = rnd(0, 1023); vc = rnd(0, 1023); end
        1: begin hc = m_car + rnd(-24, 23); vc = rnd(396, 443); end
        2: begin sl = rnd(0, NO - 1); hc = center(m_olane[sl]) + rnd(-24, 23); vc = m_oy[sl] + rnd(-4, 43); end
        default: begin hc = L0 + LP / 2 + LP * rnd(0, NL - 2) + rnd(-1, 1); vc = rnd(0, 479); end
      endcase
      hc = (hc < 0) ? 0 : (hc > 1023) ? 1023 : hc;
      vc = (vc < 0) ? 0 : (vc > 1023) ? 1023 : vc;
      hcount = 10'(hc); vcount = 10'(vc);
      if (hold_cnt > 0) begin
        hold_cnt--;
      end else if (btn_l || btn_r || btn_c) begin
        btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0; hold_cnt = rnd(0, 3);
      end else begin
        pick = rnd(0, 99);
        if (m_st != 1) btn_c = (pick < 25);
        else if (pick == 0) btn_c = 1'b1;
        else if (lane_busy(m_lane, 200) != 0 && pick < 70) begin
          if (m_lane > 0 && lane_busy(m_lane - 1, 80) == 0) btn_l = 1'b1;
          else if (m_lane < NL - 1 && lane_busy(m_lane + 1, 80) == 0) btn_r = 1'b1;
          else btn_l = 1'b1;
        end
        else if (pick < 8) btn_l = 1'b1;
        else if (pick < 16) btn_r = 1'b1;
        else if (pick < 18) begin btn_l = 1'b1; btn_r = 1'b1; end
        hold_cnt = rnd(0, 5);
      end
      cyc();
    end

    // Reset from arbitrary mid-game state clears everything on the next clock.
    reset = 1'b1; btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0; bright = 1'b1;
    cyc();
    check("reset_mid_state", 32'(game_state), 32'd0);
    check("reset_mid_score", 32'(score), 32'd0);
    check("reset_mid_high", 32'(high_score), 32'd0);
    check("reset_mid_rgb", 32'(rgb), 32'd0);
    reset = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lane_runner_core.md
LANE_RUNNER_CORE -- requirements
Module: lane_runner_core

Interface
REQ-001 SHALL have parameter NUM_LANES, default 3, number of lanes (legal 2..7).
REQ-002 SHALL have parameter NUM_OBS, default 4, number of obstacle slots (legal 1..8).
REQ-003 SHALL have parameter LANE0_X, default 220, center X of lane 0; LANE_PITCH, default 140, center spacing.
REQ-004 SHALL have parameter TICK_BITS, default 22, width of the free-running game-tick counter.
REQ-005 SHALL have parameters SPAWN_GAP, default 40, ticks between spawn attempts; SPEED_UP_EVERY, default 5, points per speed level; MAX_STEP, default 8, max obstacle pixels/tick.
REQ-006 SHALL have port clk, input, 1, system clock; the block uses one clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports btn_l, btn_r, btn_c, input, 1 each, debounced button levels.
REQ-009 SHALL have port bright, input, 1, visible-area flag; hcount, vcount, input, 10 each, pixel coordinates.
REQ-010 SHALL have port rgb, output, 12, registered pixel color.
REQ-011 SHALL have port score, output, 16, current score; high_score, output, 16, best score since reset.
REQ-012 SHALL have port game_state, output, 2, START=0, PLAY=1, GAMEOVER=2, PAUSE=3.

Function
REQ-013 Tick: TICK_BITS counter SHALL increment every clk and wrap; tick asserts for one clk when counter == 0, in all states.
REQ-014 Buttons SHALL be rising-edge detected with one registered stage; only edges cause actions; held levels never repeat.
REQ-015 START: lane = NUM_LANES/2, car_x = that lane's center, all slots invalid, score = 0, speed level = 0, spawn counter = 0; btn_c edge -> PLAY.
REQ-016 PLAY: btn_c edge -> PAUSE; PAUSE: everything frozen, btn_c edge -> PLAY; GAMEOVER: frozen, btn_c edge -> START.
REQ-017 Lane change SHALL be accepted only when car_x == target center: btn_l edge decrements lane if lane > 0, btn_r edge increments if lane < NUM_LANES-1, else ignored; simultaneous btn_l and btn_r edges SHALL be ignored.
REQ-018 Car slide: on each tick car_x moves 5 px toward target; if remaining distance < 5, car_x SHALL snap to target (never overshoot).
REQ-019 Obstacle slot = {valid, lane, y[9:0]}, 40x40 px; each tick every valid slot y += step, step = min(1 + level, MAX_STEP).
REQ-020 Slot with y >= 480 after update SHALL be invalidated and score += 1 per retired slot, saturating at 16'hFFFF; level increments each time score crosses a multiple of SPEED_UP_EVERY.
REQ-021 Spawn counter SHALL count ticks; at SPAWN_GAP it resets to 0 and the lowest-index invalid slot becomes valid with y = 0, lane = lfsr % NUM_LANES; if no slot free the spawn is dropped.
REQ-022 LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, seed 8'hAC, advances every clk.
REQ-023 Player box: x in [car_x-20, car_x+20), y in [400, 440).
REQ-024 Collision: any valid slot whose box strictly overlaps the player box in both X and Y; in PLAY, collision SHALL move state to GAMEOVER on the next clk, with retirements/score of that same cycle still applied.
REQ-025 On entry to GAMEOVER, high_score <= max(high_score, score); high_score survives START.
REQ-026 Rendering priority, registered (1 clk latency): !bright -> 0; player -> WHITE (RED in GAMEOVER); obstacle -> GREEN (RED if it is the colliding slot in GAMEOVER); lane divider, 1 px gray (12'h888) midway between adjacent lane centers -> GRAY; else BLACK.

Reset
REQ-027 reset SHALL, on the clk edge it is sampled high, force state START and all REQ-015 values, high_score = 0, lfsr = 8'hAC, tick counter = 0, rgb = 0, edge registers = 0; reset SHALL override any in-flight slide, spawn or collision.

Verification
REQ-028 Reset, then btn_c edge -> game_state 1 two clks later; btn_c held 100 clks -> state changes once only.
REQ-029 TICK_BITS=4, lane 1, btn_r edge -> car_x 360,365,...,500 on successive ticks, stops at 500; second btn_r ignored at lane 2.
REQ-030 SPAWN_GAP=1, NUM_OBS=2, obstacles never collide -> third spawn dropped while both slots valid; slot retirement at y >= 480 -> score increments by 1 each.
REQ-031 Force obstacle into player lane -> GAMEOVER; score 7, prior high_score 3 -> high_score 7; player and obstacle pixels read 12'hF00.
REQ-032 PLAY, btn_c edge -> PAUSE: obstacle y, car_x, score unchanged for 50 ticks; btn_c edge -> PLAY resumes from same values.
REQ-033 Assert reset mid-slide with score 12 -> next clk: state 0, score 0, high_score 0, rgb 0, all slots invalid.
